fir_inverse_filter: RTL and testbench
=====================================

# fir_inverse_filter

Streaming inverse (deconvolution) filter that exactly undoes the team's 4-tap monic FIR filter (h = 1, 2, 3, 4). It computes `out[n] = in[n] − Σ h[k]·out[n−k]` for k = 1…TAPS−1, modulo 2^DATA_W, and uses one multiplier sequentially across taps. It sits at the receive end of a filtered sample link. Feeding it the truncated 16-bit output of the FIR reproduces the original FIR input bit-exactly.

## Interface
- DATA_W, 16, sample and coefficient width; all arithmetic is mod 2^DATA_W.
- TAPS, 4, filter length including h[0]; legal range 2–8.
- COEF_INIT, {16'd4,16'd3,16'd2,16'd1}, packed coefficients, h[0] in the LSBs. h[0] is architecturally 1 and the h[0] field is ignored.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear: zeroes the history, aborts any sample in flight, returns to IDLE.
- in_data  in  DATA_W  filtered input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample; equals (state == IDLE).
- out_data  out  DATA_W  recovered sample; registered.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- coef_we, coef_addr[$clog2(TAPS)-1:0], coef_data[DATA_W-1:0]  in  coefficient write port; present only with FIR_INV_COEF_LOAD_EN.

## Operation
- FSM states:
  - IDLE: in_ready=1. An in_valid&&in_ready handshake loads acc←in_data and k←1, then goes to MAC.
  - MAC: each cycle acc←acc − (h[k]·hist[k−1])[DATA_W−1:0] and k←k+1. When k==TAPS−1 is processed, go to OUT.
  - OUT: out_valid=1 and out_data=acc. On out_ready, hist shifts (hist[0]←acc, hist[j]←hist[j−1]) and the FSM returns to IDLE.
- hist holds the last TAPS−1 outputs; hist[0] is the newest. Its reset value is all zero.
- All products and the accumulator are truncated to DATA_W bits. No saturation is performed, so the inversion is exact modulo 2^DATA_W.
- History updates only on the output handshake.
- clr has priority over every other event in the same cycle. An in-flight sample is dropped and out_valid deasserts on the next edge.
- The upstream handshake is never lost: in_ready is low throughout MAC and OUT.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, acc=0, k=0, hist all 0.
- Reset asserted mid-MAC or mid-OUT discards the sample immediately (asynchronous).
- Latency: if the input is accepted at edge E0, out_valid rises after edge E(TAPS−1). For TAPS=4 that is 3 cycles.
- Throughput: with out_ready tied high, one sample per TAPS+1 cycles.
- While out_valid=1 and out_ready=0, out_data is held stable. in_valid is ignored in that state.
- A new input can be accepted no earlier than the edge after the output handshake. There is no overlap.

## Configuration
- FIR_INV_COEF_LOAD_EN defined:
  - The coef_we/coef_addr/coef_data ports exist and coefficients live in registers initialised from COEF_INIT at reset.
  - A write takes effect only when state==IDLE and clr is low. Writes in any other state are silently dropped.
  - A write to addr 0 is ignored, because h[0] is always 1.
- FIR_INV_COEF_LOAD_EN undefined: the coefficient ports are absent and coefficients are constants taken from COEF_INIT.

## Structure
- Package fir_inv_pkg holds:
  - the state enum (IDLE, MAC, OUT);
  - the DATA_W_DEF=16 and TAPS_DEF=4 constants;
  - the default COEF_INIT constant, shared with the FIR filter so both ends stay matched.
- One sub-module, fir_inv_hist, is natural: a TAPS−1 deep history shift register with shift-enable, clear, and an indexed read port.
- The FSM, the multiplier and the accumulator stay in the top level.

## Test plan
- Inverse of FIR impulse response: in 1,2,3,4 → out 0x0001,0x0000,0x0000,0x0000.
- Impulse with wrap-around: in 1,0,0,0 → out 0x0001,0xFFFE,0x0001,0x0000.
- Backpressure:
  - Hold out_ready=0 for 5 cycles → out_data is stable, in_ready=0 and in_valid is ignored.
  - Releasing out_ready completes the handshake, then in_ready=1 on the next cycle.
- clr and reset:
  - After 3 samples, pulse clr during MAC → no output is produced, and the next input 7 gives out 7 (history zero).
  - Asserting reset during OUT gives the same result.
- Round trip: 200 random 16-bit x drive a behavioural FIR model (h=1,2,3,4, low 16 bits) into the block → the output equals x exactly, with latency 3 and cadence 5 cycles.
- With FIR_INV_COEF_LOAD_EN:
  - Write h[1]=5 while IDLE, then in 1,0 → out 0x0001,0xFFFB.
  - A write attempted during MAC is ignored.

Source files
------------

// File: rtl/fir_inv_pkg.sv
// fir_inv_pkg
// Shared definitions for the inverse (deconvolution) filter and the matching
// 4-tap FIR on the transmit side of the sample link.
//   state_t        : inverse-filter FSM states (IDLE, MAC, OUT)
//   DATA_W_DEF     : default sample / coefficient width
//   TAPS_DEF       : default filter length including h[0]
//   COEF_INIT_DEF  : default packed coefficients, h[0] in the LSBs.
//                    The FIR filter uses the same constant, so both ends
//                    stay matched.
package fir_inv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TAPS_DEF   = 4;

    localparam logic [DATA_W_DEF*TAPS_DEF-1:0] COEF_INIT_DEF =
        {16'd4, 16'd3, 16'd2, 16'd1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fir_inv_hist.sv
// fir_inv_hist
// History of the most recent recovered outputs for the inverse filter.
// Entry 0 is the newest output; entry DEPTH-1 is the oldest.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset (history to zero)
//   clr        : synchronous clear (history to zero), wins over shift
//   shift      : push shift_data in as the newest entry
//   shift_data : value pushed on shift
//   rd_addr    : index of the entry to read (0 = newest)
//   rd_data    : combinational read of entry rd_addr
module fir_inv_hist
    import fir_inv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = TAPS_DEF - 1,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift,
    input  logic [DATA_W-1:0] shift_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] hist [DEPTH];

    // Shift register of past outputs; clear has priority over a shift so an
    // aborted stream never leaves stale samples behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (shift) begin
            hist[0] <= shift_data;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    assign rd_data = hist[rd_addr];

endmodule

// File: rtl/fir_inverse_filter.sv
// fir_inverse_filter
// Streaming inverse of the monic FIR h = {1, h[1], ..., h[TAPS-1]}:
//   out[n] = in[n] - sum_{k=1..TAPS-1} h[k]*out[n-k]   (mod 2^DATA_W)
// A single multiplier is reused across taps, one tap per cycle.
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   clr                 : synchronous clear of history and in-flight sample
//   in_data/in_valid    : input sample stream, in_ready = (state == IDLE)
//   out_data/out_valid  : recovered sample (registered), out_ready from sink
//   coef_we/coef_addr/coef_data : runtime coefficient writes, only when the
//                         FIR_INV_COEF_LOAD_EN macro is defined
module fir_inverse_filter
    import fir_inv_pkg::*;
#(
    parameter int                     DATA_W    = DATA_W_DEF,
    parameter int                     TAPS      = TAPS_DEF,
    parameter logic [DATA_W*TAPS-1:0] COEF_INIT = COEF_INIT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
`ifdef FIR_INV_COEF_LOAD_EN
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [DATA_W-1:0]        coef_data,
`endif
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int KW = $clog2(TAPS);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] acc;
    logic [KW-1:0]     k;
    logic [DATA_W-1:0] coef [TAPS];
    logic [DATA_W-1:0] hist_rd;
    logic [DATA_W-1:0] product;
    logic [KW-1:0]     hist_addr;
    logic              accept;
    logic              out_fire;
    logic              last_tap;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_data  = acc;
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_tap  = (k == KW'(TAPS - 1));

    // Tap k multiplies the output from k samples ago, which sits at
    // history index k-1. Only the low DATA_W bits of the product matter.
    assign hist_addr = k - KW'(1);
    assign product   = coef[k] * hist_rd;

`ifdef FIR_INV_COEF_LOAD_EN
    // Writable coefficients. Writes are only honoured while idle so a sample
    // never sees a coefficient change halfway through its MAC sequence.
    // Entry 0 is never written because h[0] is fixed at 1 and never read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= COEF_INIT[i*DATA_W +: DATA_W];
            end
        end else if (coef_we && (state == IDLE) && !clr &&
                     (coef_addr != '0) && (int'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_data;
        end
    end
`else
    for (genvar g = 0; g < TAPS; g++) begin : g_coef
        assign coef[g] = COEF_INIT[g*DATA_W +: DATA_W];
    end
`endif

    fir_inv_hist #(
        .DATA_W (DATA_W),
        .DEPTH  (TAPS - 1),
        .AW     (KW)
    ) u_hist (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .shift      (out_fire && !clr),
        .shift_data (acc),
        .rd_addr    (hist_addr),
        .rd_data    (hist_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept -> TAPS-1 MAC cycles -> hold in OUT until the sink
    // takes the sample. clr overrides everything and drops the sample.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)    state_next = MAC;
            MAC:  if (last_tap)  state_next = OUT;
            OUT:  if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
        if (clr) begin
            state_next = IDLE;
        end
    end

    // Accumulator and tap counter. acc doubles as the output register, so it
    // is left untouched in OUT to keep out_data stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            k   <= '0;
        end else if (clr) begin
            acc <= '0;
            k   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= in_data;
                        k   <= KW'(1);
                    end
                end
                MAC: begin
                    acc <= acc - product;
                    k   <= last_tap ? '0 : k + KW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_inverse_filter.sv
// tb_fir_inverse_filter
// Bench for fir_inverse_filter with the default TAPS=4, h = 1,2,3,4.
// Build with FIR_INV_COEF_LOAD_EN defined to also exercise coefficient writes.
module tb_fir_inverse_filter;

    localparam int DW = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          clr       = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
`ifdef FIR_INV_COEF_LOAD_EN
    logic          coef_we   = 1'b0;
    logic [1:0]    coef_addr = '0;
    logic [DW-1:0] coef_data = '0;
`endif

    int errors      = 0;
    int checks      = 0;
    int cycle       = 0;
    int last_accept = 0;

    int            h_coef [4] = '{1, 2, 3, 4};
    logic [DW-1:0] y_hist [4];
    logic [DW-1:0] x_hist [4];

    fir_inverse_filter dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef FIR_INV_COEF_LOAD_EN
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one sample, then wait (bounded) until out_valid; lat counts the
    // edges after the accepting edge.
    task automatic applyStimulus(input logic [DW-1:0] din, output int lat);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("in_ready_before_send", 32'(in_ready), 32'd1);
        in_data  = din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        last_accept = cycle;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic sendAndCollect(input logic [DW-1:0] din,
                                  input logic [DW-1:0] exp, input string tag);
        int lat;
        applyStimulus(din, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
        checkOutput(tag, 32'(out_data), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            y_hist[i] = '0;
            x_hist[i] = '0;
        end
    endtask

    // Reference inverse: y = x - sum h[k]*y[n-k], low 16 bits.
    function automatic logic [DW-1:0] invModel(input logic [DW-1:0] x);
        int s;
        logic [DW-1:0] y;
        s = int'(x);
        for (int j = 1; j < 4; j++) s = s - h_coef[j] * int'(y_hist[j]);
        y = s[DW-1:0];
        for (int j = 3; j > 1; j--) y_hist[j] = y_hist[j-1];
        y_hist[1] = y;
        return y;
    endfunction

    // Reference forward FIR on the transmit side, low 16 bits.
    function automatic logic [DW-1:0] firModel(input logic [DW-1:0] x);
        int s;
        for (int j = 3; j > 0; j--) x_hist[j] = x_hist[j-1];
        x_hist[0] = x;
        s = 0;
        for (int j = 0; j < 4; j++) s = s + h_coef[j] * int'(x_hist[j]);
        return s[DW-1:0];
    endfunction

    initial begin
        int            lat;
        int            prev;
        logic          seen;
        logic [DW-1:0] x;
        logic [DW-1:0] f;

        $display("[TB] start");
        for (int i = 0; i < 4; i++) begin
            y_hist[i] = '0;
            x_hist[i] = '0;
        end

        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #3;
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data",  32'(out_data),  32'd0);
        @(posedge clk); #1;

        // FIR impulse response fed back in
        pulseClr();
        sendAndCollect(16'd1, 16'h0001, "fir_imp0");
        sendAndCollect(16'd2, 16'h0000, "fir_imp1");
        sendAndCollect(16'd3, 16'h0000, "fir_imp2");
        sendAndCollect(16'd4, 16'h0000, "fir_imp3");

        // plain impulse, negative values wrap
        pulseClr();
        sendAndCollect(16'd1, 16'h0001, "imp0");
        sendAndCollect(16'd0, 16'hFFFE, "imp1");
        sendAndCollect(16'd0, 16'h0001, "imp2");
        sendAndCollect(16'd0, 16'h0000, "imp3");

        // backpressure
        pulseClr();
        out_ready = 1'b0;
        applyStimulus(16'd9, lat);
        checkOutput("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_data",  32'(out_data),  32'd9);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready",   32'(in_ready),  32'd0);
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_in_ready",  32'(in_ready),  32'd1);
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        sendAndCollect(16'd0, 16'hFFEE, "bp_next");

        // clr during MAC
        pulseClr();
        for (int i = 0; i < 3; i++) begin
            x = DW'($urandom);
            sendAndCollect(x, invModel(x), "clr_pre");
        end
        in_data  = DW'($urandom);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        pulseClr();
        checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
        checkOutput("clr_in_ready",  32'(in_ready),  32'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        checkOutput("clr_no_output", 32'(seen), 32'd0);
        sendAndCollect(16'd7, 16'd7, "clr_after");

        // reset during OUT
        pulseClr();
        for (int i = 0; i < 3; i++) begin
            x = DW'($urandom);
            sendAndCollect(x, invModel(x), "rst_pre");
        end
        out_ready = 1'b0;
        applyStimulus(DW'($urandom), lat);
        checkOutput("rst_in_out", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_data",  32'(out_data),  32'd0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        sendAndCollect(16'd7, 16'd7, "rst_after");

        // random round trip through the forward FIR
        pulseClr();
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            x = DW'($urandom);
            f = firModel(x);
            sendAndCollect(f, x, "roundtrip");
            if (i > 0) checkOutput("roundtrip_cadence", 32'(last_accept - prev), 32'd5);
            prev = last_accept;
        end

`ifdef FIR_INV_COEF_LOAD_EN
        pulseClr();
        coef_we   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 16'd5;
        @(posedge clk); #1;
        coef_we = 1'b0;
        sendAndCollect(16'd1, 16'h0001, "coef_w0");
        sendAndCollect(16'd0, 16'hFFFB, "coef_w1");

        pulseClr();
        in_data  = 16'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 16'd9;
        @(posedge clk); #1;
        coef_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("coef_mac_out0", 32'(out_data), 32'h0001);
        @(posedge clk); #1;
        sendAndCollect(16'd0, 16'hFFFB, "coef_mac_ignored");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
